// File: rtl/rv_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rv_multicycle_ctrl
// Brief    : Multi-cycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB) with
//            req/ack memory handshake, wait-state timeout, stall and traps.
// Revision : 1.0 - initial release
// ============================================================================
module rv_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int ALUOP_W     = 2,
    parameter int RET_CNT_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          instr,
    input  logic                 mem_ack,
    input  logic                 branch_taken,
    input  logic                 stall,
    input  logic                 trap_clr,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 mem_addr_sel,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic [1:0]           pc_src,
    output logic                 alu_src_a,
    output logic                 alu_src_b,
    output logic [ALUOP_W-1:0]   alu_op,
    output logic                 reg_write,
    output logic [1:0]           mem_to_reg,
    output logic                 retire,
    output logic [RET_CNT_W-1:0] ret_count,
    output logic                 trap,
    output logic [1:0]           trap_cause
);

    localparam logic [2:0] c_S_RST    = 3'd0;
    localparam logic [2:0] c_S_FETCH  = 3'd1;
    localparam logic [2:0] c_S_DECODE = 3'd2;
    localparam logic [2:0] c_S_EXEC   = 3'd3;
    localparam logic [2:0] c_S_MEM    = 3'd4;
    localparam logic [2:0] c_S_WB     = 3'd5;
    localparam logic [2:0] c_S_TRAP   = 3'd6;

    localparam logic [4:0] c_OP_R      = 5'b01100;
    localparam logic [4:0] c_OP_I      = 5'b00100;
    localparam logic [4:0] c_OP_LOAD   = 5'b00000;
    localparam logic [4:0] c_OP_STORE  = 5'b01000;
    localparam logic [4:0] c_OP_BRANCH = 5'b11000;
    localparam logic [4:0] c_OP_JAL    = 5'b11011;
    localparam logic [4:0] c_OP_JALR   = 5'b11001;
    localparam logic [4:0] c_OP_AUIPC  = 5'b00101;
    localparam logic [4:0] c_OP_LUI    = 5'b01101;

    localparam logic [ALUOP_W-1:0] c_ALU_ADD    = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] c_ALU_BRANCH = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] c_ALU_FUNCT  = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] c_ALU_PASSB  = ALUOP_W'(3);

    localparam logic [1:0] c_PC_PLUS4 = 2'b00;
    localparam logic [1:0] c_PC_TGT   = 2'b01;
    localparam logic [1:0] c_PC_JALR  = 2'b10;

    localparam int                c_TO_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = (MEM_TIMEOUT > 0) ? c_TO_W'(MEM_TIMEOUT - 1) : '0;

    logic [2:0]           r_state;
    logic [4:0]           r_cls;
    logic [c_TO_W-1:0]    r_tmo;
    logic [RET_CNT_W-1:0] r_cnt;
    logic [1:0]           r_cause;
    logic [2:0]           w_next;
    logic                 w_legal;
    logic                 w_tmo_hit;
    logic                 w_unused_instr;

    assign w_unused_instr = ^instr[31:7];
    assign w_legal   = (instr[1:0] == 2'b11) &&
                       (instr[6:2] inside {c_OP_R, c_OP_I, c_OP_LOAD, c_OP_STORE, c_OP_BRANCH,
                                           c_OP_JAL, c_OP_JALR, c_OP_AUIPC, c_OP_LUI});
    assign w_tmo_hit = (MEM_TIMEOUT != 0) && (r_tmo == c_TO_LAST);

    // An ack in the final allowed wait cycle takes priority over the timeout.
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_S_RST:    w_next = c_S_FETCH;
            c_S_FETCH: begin
                if (mem_ack)        w_next = c_S_DECODE;
                else if (w_tmo_hit) w_next = c_S_TRAP;
            end
            c_S_DECODE: if (!stall) w_next = w_legal ? c_S_EXEC : c_S_TRAP;
            c_S_EXEC: begin
                if (!stall) begin
                    case (r_cls)
                        c_OP_LOAD, c_OP_STORE:            w_next = c_S_MEM;
                        c_OP_BRANCH, c_OP_JAL, c_OP_JALR: w_next = c_S_FETCH;
                        default:                          w_next = c_S_WB;
                    endcase
                end
            end
            c_S_MEM: begin
                if (mem_ack)        w_next = (r_cls == c_OP_STORE) ? c_S_FETCH : c_S_WB;
                else if (w_tmo_hit) w_next = c_S_TRAP;
            end
            c_S_WB:     if (!stall) w_next = c_S_FETCH;
            c_S_TRAP:   if (trap_clr) w_next = c_S_FETCH;
            default:    w_next = c_S_FETCH;
        endcase
    end

    // Handshake outputs come from state only; completion strobes qualify on ack/stall.
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = c_PC_PLUS4;
        alu_src_a    = 1'b0;
        alu_src_b    = 1'b0;
        alu_op       = c_ALU_ADD;
        reg_write    = 1'b0;
        mem_to_reg   = 2'b00;
        retire       = 1'b0;
        trap         = 1'b0;
        case (r_state)
            c_S_FETCH: begin
                mem_req  = 1'b1;
                ir_write = mem_ack;
            end
            c_S_EXEC: begin
                case (r_cls)
                    c_OP_R: alu_op = c_ALU_FUNCT;
                    c_OP_I: begin
                        alu_op    = c_ALU_FUNCT;
                        alu_src_b = 1'b1;
                    end
                    c_OP_LOAD, c_OP_STORE: alu_src_b = 1'b1;
                    c_OP_BRANCH: begin
                        alu_op   = c_ALU_BRANCH;
                        pc_write = !stall;
                        retire   = !stall;
                        pc_src   = branch_taken ? c_PC_TGT : c_PC_PLUS4;
                    end
                    c_OP_JAL, c_OP_JALR: begin
                        pc_write   = !stall;
                        reg_write  = !stall;
                        retire     = !stall;
                        mem_to_reg = 2'b10;
                        pc_src     = (r_cls == c_OP_JALR) ? c_PC_JALR : c_PC_TGT;
                    end
                    c_OP_AUIPC: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 1'b1;
                    end
                    c_OP_LUI: begin
                        alu_op    = c_ALU_PASSB;
                        alu_src_b = 1'b1;
                    end
                    default: ;
                endcase
            end
            c_S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (r_cls == c_OP_STORE);
                if (r_cls == c_OP_STORE) begin
                    pc_write = mem_ack;
                    retire   = mem_ack;
                end
            end
            c_S_WB: begin
                reg_write  = !stall;
                pc_write   = !stall;
                retire     = !stall;
                mem_to_reg = (r_cls == c_OP_LOAD) ? 2'b01 :
                             (r_cls == c_OP_LUI)  ? 2'b11 : 2'b00;
            end
            c_S_TRAP: trap = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_S_RST;
            r_cls   <= 5'b0;
            r_tmo   <= '0;
            r_cnt   <= '0;
            r_cause <= 2'b00;
        end else begin
            r_state <= w_next;
            if (r_state == c_S_DECODE) r_cls <= instr[6:2];
            if ((r_state == c_S_FETCH || r_state == c_S_MEM) && w_next == r_state)
                r_tmo <= r_tmo + 1'b1;
            else
                r_tmo <= '0;
            if (retire) r_cnt <= r_cnt + 1'b1;
            if (w_next == c_S_TRAP && r_state == c_S_DECODE)
                r_cause <= 2'b01;
            else if (w_next == c_S_TRAP && (r_state == c_S_FETCH || r_state == c_S_MEM))
                r_cause <= 2'b10;
            else if (r_state == c_S_TRAP && trap_clr)
                r_cause <= 2'b00;
        end
    end

    assign ret_count  = r_cnt;
    assign trap_cause = r_cause;

endmodule
`default_nettype wire

// File: tb/tb_rv_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_multicycle_ctrl
// Brief    : Scoreboard bench for rv_multicycle_ctrl; directed instruction
//            sequence with hand-computed retire/trap events and latencies.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        mem_ack = 1'b0;
    logic        branch_taken;
    logic        stall;
    logic        trap_clr;
    logic        mem_req, mem_we, mem_addr_sel, ir_write, pc_write;
    logic [1:0]  pc_src;
    logic        alu_src_a, alu_src_b;
    logic [1:0]  alu_op;
    logic        reg_write;
    logic [1:0]  mem_to_reg;
    logic        retire;
    logic [31:0] ret_count;
    logic        trap;
    logic [1:0]  trap_cause;

    rv_multicycle_ctrl #(.MEM_TIMEOUT(16), .ALUOP_W(2), .RET_CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ack(mem_ack),
        .branch_taken(branch_taken), .stall(stall), .trap_clr(trap_clr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .retire(retire),
        .ret_count(ret_count), .trap(trap), .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [42:0] vec;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   wait_n = 0;
    int   rcnt   = 0;
    int   memc;
    logic we_l;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
        end
    endtask

    task automatic push(input string n, input logic tr, input logic [1:0] tc, input logic pcw,
                        input logic [1:0] ps, input logic rw, input logic [1:0] m2r,
                        input logic we, input logic asel, input logic [31:0] rc, input int lat);
        exp_t e;
        e.name = n;
        e.vec  = {tr, tc, pcw, ps, rw, m2r, we, asel, rc};
        e.lat  = lat;
        sb.push_back(e);
    endtask

    // Memory model: acks after wait_n wait states on every request.
    always begin
        @(posedge clk);
        #2;
        if (mem_req) begin
            if (rcnt >= wait_n) begin
                mem_ack = 1'b1;
                rcnt    = 0;
            end else begin
                mem_ack = 1'b0;
                rcnt++;
            end
        end else begin
            mem_ack = 1'b0;
            rcnt    = 0;
        end
    end

    // Monitor: pops on each retire or trap entry, measuring latency from FETCH start.
    int   cyc    = 0;
    int   t0     = 0;
    logic busy   = 1'b0;
    logic trap_q = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst_n) begin
            busy   = 1'b0;
            trap_q = 1'b0;
        end else begin
            if (!busy && mem_req && !mem_addr_sel) begin
                busy = 1'b1;
                t0   = cyc;
            end
            if (retire || (trap && !trap_q)) begin
                if (sb.size() == 0) begin
                    chk("unexpected_event", {retire, trap}, 2'b00);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_outs"}, {trap, trap_cause, pc_write, pc_src, reg_write,
                                            mem_to_reg, mem_we, mem_addr_sel, ret_count}, e.vec);
                    chk({e.name, "_latency"}, cyc - t0 + 1, e.lat);
                end
                busy = 1'b0;
            end
            trap_q = trap;
        end
    end

    // Starts at a negedge in the cycle before FETCH; returns at the event negedge.
    task automatic run(input logic [31:0] ins, input int wn, input logic bt,
                       input int sfrom, input int slen, input int skind);
        int   k = 0;
        logic done = 1'b0;
        wait_n = wn;
        memc   = 0;
        we_l   = 1'b0;
        while (!done && k < 40) begin
            @(posedge clk);
            #1;
            trap_clr     = 1'b0;
            instr        = ins;
            branch_taken = bt;
            k++;
            stall = (k >= sfrom) && (k < sfrom + slen);
            @(negedge clk);
            if (stall) begin
                if (skind == 1) chk("stall_strobes", {ir_write, pc_write, reg_write, retire}, 4'b0000);
                else            chk("stall_fetch_req", {mem_req, ir_write}, 2'b10);
            end
            if (mem_req && mem_addr_sel) begin
                memc++;
                we_l = mem_we;
            end
            if (retire || trap) done = 1'b1;
        end
        if (!done) chk("event_timeout", 1, 0);
    endtask

    task automatic clear_trap();
        @(posedge clk);
        #1;
        trap_clr = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; instr = 32'h00000013; stall = 1'b0; trap_clr = 1'b0; branch_taken = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src, alu_src_a,
                           alu_src_b, alu_op, reg_write, mem_to_reg, retire, trap, trap_cause}, 0);
        chk("reset_ret_count", ret_count, 0);
        rst_n = 1'b1;

        push("add",     0, 2'b00, 1, 2'b00, 1, 2'b00, 0, 0, 0, 4);
        run(32'h002081B3, 0, 0, 0, 0, 0);
        push("lw",      0, 2'b00, 1, 2'b00, 1, 2'b01, 0, 0, 1, 9);
        run(32'h0000A103, 2, 0, 0, 0, 0);
        chk("lw_mem_cycles", memc, 3);
        chk("lw_mem_we", we_l, 0);
        push("sw",      0, 2'b00, 1, 2'b00, 0, 2'b00, 1, 1, 2, 4);
        run(32'h0020A023, 0, 0, 0, 0, 0);
        chk("sw_mem_cycles", memc, 1);
        push("beq_t",   0, 2'b00, 1, 2'b01, 0, 2'b00, 0, 0, 3, 3);
        run(32'h00208463, 0, 1, 0, 0, 0);
        push("beq_nt",  0, 2'b00, 1, 2'b00, 0, 2'b00, 0, 0, 4, 3);
        run(32'h00208463, 0, 0, 0, 0, 0);
        push("lui",     0, 2'b00, 1, 2'b00, 1, 2'b11, 0, 0, 5, 4);
        run(32'h123452B7, 0, 0, 0, 0, 0);
        push("illegal", 1, 2'b01, 0, 2'b00, 0, 2'b00, 0, 0, 6, 3);
        run(32'h0000007F, 0, 0, 0, 0, 0);
        clear_trap();
        push("timeout", 1, 2'b10, 0, 2'b00, 0, 2'b00, 0, 0, 6, 17);
        run(32'h002081B3, 1000, 0, 0, 0, 0);
        clear_trap();
        push("ack16",   0, 2'b00, 1, 2'b00, 1, 2'b00, 0, 0, 6, 19);
        run(32'h002081B3, 15, 0, 2, 4, 2);
        push("jalr",    0, 2'b00, 1, 2'b10, 1, 2'b10, 0, 0, 7, 6);
        run(32'h000080E7, 0, 0, 3, 3, 1);
        push("jal",     0, 2'b00, 1, 2'b01, 1, 2'b10, 0, 0, 8, 3);
        run(32'h008000EF, 0, 0, 0, 0, 0);
        push("addi_wb_stall", 0, 2'b00, 1, 2'b00, 1, 2'b00, 0, 0, 9, 6);
        run(32'h00108093, 0, 0, 4, 2, 1);

        wait_n = 1000;
        @(posedge clk);
        #1;
        chk("final_ret_count", ret_count, 10);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_outs", {mem_req, trap, retire}, 3'b000);
        chk("abort_ret_count", ret_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete, got %0d checks expected completion", checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
